// File: rtl/cnn_pkg.sv
// Shared CNN dimension constants used by the conv, pool and FC stages.
package cnn_pkg;

  // Pixel width and input image geometry for the pooling stage.
  localparam int unsigned CNN_DATA_W = 69;
  localparam int unsigned CNN_IMG_W  = 24;
  localparam int unsigned CNN_IMG_H  = 24;

  // Convolution stage.
  localparam int unsigned CONV_K      = 3;
  localparam int unsigned CONV_OUT_CH = 8;

  // Pooling stage.
  localparam int unsigned POOL_K     = 2;
  localparam int unsigned POOL_OUT_W = CNN_IMG_W / POOL_K;
  localparam int unsigned POOL_OUT_H = CNN_IMG_H / POOL_K;

  // Fully connected stage.
  localparam int unsigned FC_IN  = POOL_OUT_W * POOL_OUT_H * CONV_OUT_CH;
  localparam int unsigned FC_OUT = 10;

  // Number of pooled windows produced per frame.
  function automatic int unsigned pool_windows(input int unsigned img_w,
                                               input int unsigned img_h);
    return (img_w / POOL_K) * (img_h / POOL_K);
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding the row-pair maxima of the upper row of each window.
module pool_line_buf #(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned DEPTH  = 12,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Single write port; contents are never reset because every entry is
  // written on an even row before the matching odd row reads it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Combinational read port.
  assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/maxpool_stream.sv
// Streaming 2x2 max-pool over a raster-order image with valid/ready handshakes.
module maxpool_stream
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = CNN_DATA_W,
  parameter int unsigned IMG_W  = CNN_IMG_W,
  parameter int unsigned IMG_H  = CNN_IMG_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done
);

  localparam int unsigned COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned LB_DEPTH = IMG_W / 2;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;

  logic              in_ready_c;
  logic              accept_c;
  logic              drain_c;
  logic [LB_AW-1:0]  lb_addr_c;
  logic              lb_wr_en_c;
  logic [DATA_W-1:0] lb_rd_c;
  logic [DATA_W-1:0] pair_max_c;
  logic [DATA_W-1:0] win_max_c;

  // An output slot is free when empty or draining this cycle.
  assign in_ready_c = !out_valid_q || out_ready;
  assign accept_c   = in_valid && in_ready_c;
  assign drain_c    = out_valid_q && out_ready;
  assign lb_addr_c  = LB_AW'(col_q >> 1);

  // Full-width unsigned maxima of the horizontal pair and of the whole window.
  assign pair_max_c = (in_data > hold_q) ? in_data : hold_q;
  assign win_max_c  = (lb_rd_c > pair_max_c) ? lb_rd_c : pair_max_c;

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (LB_DEPTH),
    .ADDR_W (LB_AW)
  ) u_line_buf (
    .clk       (clk),
    .wr_en     (lb_wr_en_c),
    .wr_addr   (lb_addr_c),
    .wr_data   (pair_max_c),
    .rd_addr   (lb_addr_c),
    .rd_data_c (lb_rd_c)
  );

  // Next-state: raster counters, hold register, line-buffer write, output slot.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    lb_wr_en_c  = 1'b0;
    done_d      = drain_c && out_last_q;

    if (drain_c) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (accept_c) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      if (!col_q[0]) begin
        hold_d = in_data;
      end else if (!row_q[0]) begin
        lb_wr_en_c = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = win_max_c;
        out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Randomized self-checking bench for maxpool_stream against a window-max model.
module tb_maxpool_stream;

  localparam int unsigned DW   = 69;
  localparam int unsigned W    = 24;
  localparam int unsigned H    = 24;
  localparam int unsigned NPIX = W * H;
  localparam int unsigned NWIN = (W / 2) * (H / 2);

  typedef logic [DW-1:0] pix_t;
  typedef struct packed {
    pix_t data;
    logic last;
  } exp_t;

  logic clk;
  logic rst;
  logic in_valid;
  logic in_ready;
  pix_t in_data;
  logic out_valid;
  logic out_ready;
  pix_t out_data;
  logic out_last;
  logic done;

  int   total;
  int   bad;
  exp_t exp_q[$];
  pix_t frm[NPIX];
  int   done_cnt;
  int   out_cnt;
  pix_t first_out;
  pix_t last_out;
  logic last_hs;
  int   rdy_mode;
  bit   gap_mode;
  bit   pending;

  maxpool_stream #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input pix_t got, input pix_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic pix_t max4(input pix_t a, input pix_t b, input pix_t c, input pix_t d);
    pix_t m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Expected windows of the current frame whose fourth pixel lies below npix.
  function automatic void model_frame(input int npix);
    exp_t e;
    for (int i = 0; i < int'(H / 2); i++) begin
      for (int j = 0; j < int'(W / 2); j++) begin
        if ((2 * i + 1) * int'(W) + 2 * j + 1 < npix) begin
          e.data = max4(frm[(2 * i) * W + 2 * j], frm[(2 * i) * W + 2 * j + 1],
                        frm[(2 * i + 1) * W + 2 * j], frm[(2 * i + 1) * W + 2 * j + 1]);
          e.last = (i == int'(H / 2) - 1) && (j == int'(W / 2) - 1);
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  task automatic send_frame(input int npix, input bit idle_after);
    int k;
    int cyc;
    model_frame(npix);
    k   = 0;
    cyc = 0;
    while (k < npix && cyc < npix * 20 + 1000) begin
      @(posedge clk); #1;
      in_valid = (gap_mode && $urandom_range(3) == 0) ? 1'b0 : 1'b1;
      in_data  = frm[k];
      @(negedge clk);
      if (pending) begin
        check("latency", pix_t'(out_valid), pix_t'(1));
        pending = 1'b0;
      end
      if (in_valid && in_ready) begin
        pending = ((k / W) % 2 == 1) && ((k % W) % 2 == 1);
        k++;
      end
      cyc++;
    end
    if (k < npix) check("send_timeout", pix_t'(k), pix_t'(npix));
    if (idle_after) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      if (pending) begin
        check("latency", pix_t'(out_valid), pix_t'(1));
        pending = 1'b0;
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("drain", pix_t'(exp_q.size()), pix_t'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", pix_t'(in_ready), pix_t'(1));
    check("rst_out_valid", pix_t'(out_valid), pix_t'(0));
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < int'(NPIX); k++) frm[k] = pix_t'((k / W) * W + (k % W));
  endtask

  task automatic fill_rand();
    for (int k = 0; k < int'(NPIX); k++) frm[k] = pix_t'({$urandom, $urandom, $urandom});
  endtask

  task automatic clear_stats();
    out_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic check_ramp(input string tag);
    check({tag, "_first"}, first_out, pix_t'(25));
    check({tag, "_last"}, last_out, pix_t'(575));
    check({tag, "_count"}, pix_t'(out_cnt), pix_t'(NWIN));
    check({tag, "_done"}, pix_t'(done_cnt), pix_t'(1));
  endtask

  initial begin
    int   pos [4];
    pix_t big;
    int   t;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    rdy_mode  = 0;
    gap_mode  = 1'b0;
    pending   = 1'b0;
    last_hs   = 1'b0;
    clear_stats();
    first_out = '0;
    last_out  = '0;

    fork
      forever begin
        @(posedge clk); #1;
        case (rdy_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(1));
          default: out_ready = 1'b0;
        endcase
      end
      forever begin
        exp_t e;
        @(negedge clk);
        if (done || last_hs) check("done", pix_t'(done), pix_t'(last_hs));
        if (done) done_cnt++;
        last_hs = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", out_data, pix_t'(0));
            check("unexpected_cnt", pix_t'(1), pix_t'(exp_q.size()));
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_last", pix_t'(out_last), pix_t'(e.last));
          end
          if (out_cnt == 0) first_out = out_data;
          last_out = out_data;
          out_cnt++;
          last_hs = out_last;
        end
      end
      begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycles=%0d limit=%0d", 90000, 90000);
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", pix_t'(in_ready), pix_t'(1));
    check("reset_out_valid", pix_t'(out_valid), pix_t'(0));
    check("reset_out_data", out_data, pix_t'(0));
    check("reset_out_last", pix_t'(out_last), pix_t'(0));
    check("reset_done", pix_t'(done), pix_t'(0));

    // Ramp frame with a permanently ready consumer.
    fill_ramp();
    clear_stats();
    send_frame(NPIX, 1'b1);
    wait_drain();
    check_ramp("ramp");

    // Single 7 rotated through window (0,0), frames back to back.
    pos[0] = W + 1;
    pos[1] = 0;
    pos[2] = 1;
    pos[3] = W;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < int'(NPIX); k++) frm[k] = '0;
      frm[pos[f]] = pix_t'(7);
      send_frame(NPIX, f == 3);
    end
    wait_drain();

    // Consumer stalls for five cycles on the first pooled value.
    fill_ramp();
    clear_stats();
    rdy_mode = 2;
    fork
      send_frame(NPIX, 1'b1);
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!out_valid && t < 2000);
        check("stall_seen", pix_t'(out_valid), pix_t'(1));
        for (int s = 0; s < 5; s++) begin
          check("stall_in_ready", pix_t'(in_ready), pix_t'(0));
          check("stall_out_data", out_data, pix_t'(25));
          @(negedge clk);
        end
        rdy_mode = 0;
      end
    join
    wait_drain();
    check_ramp("stall");

    // Reset after 100 pixels, then a clean ramp frame.
    fill_ramp();
    send_frame(100, 1'b1);
    wait_drain();
    do_reset();
    clear_stats();
    send_frame(NPIX, 1'b1);
    wait_drain();
    check_ramp("after_rst");

    // Two random frames with continuous in_valid.
    clear_stats();
    fill_rand();
    send_frame(NPIX, 1'b0);
    fill_rand();
    send_frame(NPIX, 1'b1);
    wait_drain();
    check("b2b_count", pix_t'(out_cnt), pix_t'(2 * NWIN));
    check("b2b_done", pix_t'(done_cnt), pix_t'(2));

    // Full-width compare: 2^68 against three copies of 2^68-1.
    clear_stats();
    fill_rand();
    big = pix_t'(1) << 68;
    for (int q = 0; q < 4; q++) frm[pos[q]] = big - pix_t'(1);
    frm[pos[$urandom_range(3)]] = big;
    send_frame(NPIX, 1'b1);
    wait_drain();
    check("wide_first", first_out, big);

    // Random data, random input gaps and random back-pressure.
    clear_stats();
    gap_mode = 1'b1;
    rdy_mode = 1;
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      send_frame(NPIX, f == 2);
    end
    wait_drain();
    rdy_mode = 0;
    gap_mode = 1'b0;
    check("rand_count", pix_t'(out_cnt), pix_t'(3 * NWIN));
    check("rand_done", pix_t'(done_cnt), pix_t'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
